// File: rtl/sprite_plotter_if.sv
// Bundle of request inputs and VGA pixel outputs for the sprite plotter.
interface sprite_plotter_if;
    logic        go;
    logic [24:0] shape;
    logic [7:0]  x_in;
    logic [6:0]  y_in;
    logic [2:0]  colour_in;
    logic [7:0]  x_vga;
    logic [6:0]  y_vga;
    logic [2:0]  colour_out;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (
        output go, shape, x_in, y_in, colour_in,
        input  x_vga, y_vga, colour_out, plot, busy, done
    );

    modport slave (
        input  go, shape, x_in, y_in, colour_in,
        output x_vga, y_vga, colour_out, plot, busy, done
    );
endinterface

// File: rtl/sprite_plotter.sv
// Sprite plotter: erases the previous 5x5 sprite with the background colour, then draws
// the new one, emitting one registered pixel write per cycle to a VGA adapter.
module sprite_plotter #(
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic            clk,
    input  logic            reset_n,
    sprite_plotter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_t;

    state_t      r_state, w_state_d;
    logic [2:0]  r_col, r_row, w_col_d, w_row_d;
    logic [24:0] r_shape;
    logic [7:0]  r_x, r_prev_x;
    logic [6:0]  r_y, r_prev_y;
    logic [2:0]  r_colour;
    logic        r_prev_valid;
    logic [7:0]  r_x_vga, w_x_vga_d;
    logic [6:0]  r_y_vga, w_y_vga_d;
    logic [2:0]  r_colour_out, w_colour_d;
    logic        r_plot, r_busy, r_done;
    logic        w_plot_d, w_busy_d, w_done_d;
    logic        w_latch, w_prev_upd, w_last;
    logic [4:0]  w_pix, w_bit_idx;

    assign w_last    = (r_col == 3'd4) && (r_row == 3'd4);
    assign w_pix     = ({2'b00, r_row} * 5'd5) + {2'b00, r_col};
    assign w_bit_idx = 5'd24 - w_pix;

    // Next-state, counter and registered-output decode.
    always_comb begin
        w_state_d  = r_state;
        w_col_d    = r_col;
        w_row_d    = r_row;
        w_latch    = 1'b0;
        w_prev_upd = 1'b0;
        w_plot_d   = 1'b0;
        w_busy_d   = 1'b0;
        w_done_d   = 1'b0;
        w_x_vga_d  = r_x_vga;
        w_y_vga_d  = r_y_vga;
        w_colour_d = r_colour_out;

        // Raster advance, col fastest; wraps to 0,0 after the last pixel.
        if (r_col == 3'd4) begin
            w_col_d = 3'd0;
            w_row_d = w_last ? 3'd0 : r_row + 3'd1;
        end else begin
            w_col_d = r_col + 3'd1;
        end

        unique case (r_state)
            StIdle: begin
                w_col_d = 3'd0;
                w_row_d = 3'd0;
                // r_done high means the done pulse is on the outputs this cycle; a go
                // coincident with it must not start a new redraw.
                if (bus.go && !r_done) begin
                    w_latch   = 1'b1;
                    w_state_d = r_prev_valid ? StErase : StDraw;
                end
            end
            StErase: begin
                w_plot_d   = 1'b1;
                w_busy_d   = 1'b1;
                w_x_vga_d  = r_prev_x + {5'd0, r_col};
                w_y_vga_d  = r_prev_y + {4'd0, r_row};
                w_colour_d = BG_COLOUR;
                if (w_last) begin
                    w_state_d = StDraw;
                end
            end
            StDraw: begin
                w_plot_d   = 1'b1;
                w_busy_d   = 1'b1;
                w_x_vga_d  = r_x + {5'd0, r_col};
                w_y_vga_d  = r_y + {4'd0, r_row};
                w_colour_d = r_shape[w_bit_idx] ? r_colour : BG_COLOUR;
                if (w_last) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_done_d   = 1'b1;
                w_prev_upd = 1'b1;
                w_col_d    = 3'd0;
                w_row_d    = 3'd0;
                w_state_d  = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State, latched request, previous position and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_col        <= 3'd0;
            r_row        <= 3'd0;
            r_shape      <= 25'd0;
            r_x          <= 8'd0;
            r_y          <= 7'd0;
            r_colour     <= 3'd0;
            r_prev_x     <= 8'd0;
            r_prev_y     <= 7'd0;
            r_prev_valid <= 1'b0;
            r_x_vga      <= 8'd0;
            r_y_vga      <= 7'd0;
            r_colour_out <= 3'd0;
            r_plot       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_col        <= w_col_d;
            r_row        <= w_row_d;
            if (w_latch) begin
                r_shape  <= bus.shape;
                r_x      <= bus.x_in;
                r_y      <= bus.y_in;
                r_colour <= bus.colour_in;
            end
            if (w_prev_upd) begin
                r_prev_x     <= r_x;
                r_prev_y     <= r_y;
                r_prev_valid <= 1'b1;
            end
            r_x_vga      <= w_x_vga_d;
            r_y_vga      <= w_y_vga_d;
            r_colour_out <= w_colour_d;
            r_plot       <= w_plot_d;
            r_busy       <= w_busy_d;
            r_done       <= w_done_d;
        end
    end

    assign bus.x_vga      = r_x_vga;
    assign bus.y_vga      = r_y_vga;
    assign bus.colour_out = r_colour_out;
    assign bus.plot       = r_plot;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_sprite_plotter.sv
// Bench for sprite_plotter: a pixel-list model predicts every output cycle, plus
// hand-computed literal expectations for the directed runs.
module tb_sprite_plotter;

    localparam logic [2:0]  BG  = 3'b000;
    localparam logic [24:0] SHP = 25'b1111110101101011111110101;
    localparam int          NCAP = 61;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    sprite_plotter_if bus ();

    sprite_plotter #(.BG_COLOUR(BG)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: per-cycle expected outputs ----------------
    typedef struct packed {
        logic       plot;
        logic       busy;
        logic       done;
        logic       chk;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } rec_t;

    rec_t exp_q[$];
    rec_t cur;
    logic [7:0] m_prev_x;
    logic [6:0] m_prev_y;
    logic       m_prev_valid;
    int         m_run_len;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            cur          = '{plot: 1'b0, busy: 1'b0, done: 1'b0, chk: 1'b1,
                             x: 8'd0, y: 7'd0, c: 3'd0};
            m_prev_x     = 8'd0;
            m_prev_y     = 7'd0;
            m_prev_valid = 1'b0;
            m_run_len    = 0;
        end else begin
            bit          accept;
            logic [24:0] s;
            logic [7:0]  nx;
            logic [6:0]  ny;
            logic [2:0]  nc;
            rec_t        r;
            accept = bus.go && (exp_q.size() == 0) && !cur.done;
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            else cur = '{plot: 1'b0, busy: 1'b0, done: 1'b0, chk: 1'b0,
                         x: 8'd0, y: 7'd0, c: 3'd0};
            if (accept) begin
                s  = bus.shape;
                nx = bus.x_in;
                ny = bus.y_in;
                nc = bus.colour_in;
                m_run_len = m_prev_valid ? 50 : 25;
                if (m_prev_valid) begin
                    for (int rr = 0; rr < 5; rr++) begin
                        for (int cc = 0; cc < 5; cc++) begin
                            r.plot = 1'b1; r.busy = 1'b1; r.done = 1'b0; r.chk = 1'b1;
                            r.x = m_prev_x + 8'(cc);
                            r.y = m_prev_y + 7'(rr);
                            r.c = BG;
                            exp_q.push_back(r);
                        end
                    end
                end
                for (int rr = 0; rr < 5; rr++) begin
                    for (int cc = 0; cc < 5; cc++) begin
                        r.plot = 1'b1; r.busy = 1'b1; r.done = 1'b0; r.chk = 1'b1;
                        r.x = nx + 8'(cc);
                        r.y = ny + 7'(rr);
                        r.c = s[24 - (5 * rr + cc)] ? nc : BG;
                        exp_q.push_back(r);
                    end
                end
                r = '{plot: 1'b0, busy: 1'b0, done: 1'b1, chk: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0};
                exp_q.push_back(r);
                m_prev_x     = nx;
                m_prev_y     = ny;
                m_prev_valid = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    int run_plots = 0;

    always @(negedge clk) begin
        chk("plot", 32'(bus.plot), 32'(cur.plot));
        chk("busy", 32'(bus.busy), 32'(cur.busy));
        chk("done", 32'(bus.done), 32'(cur.done));
        if (cur.chk) begin
            chk("x_vga", 32'(bus.x_vga), 32'(cur.x));
            chk("y_vga", 32'(bus.y_vga), 32'(cur.y));
            chk("colour_out", 32'(bus.colour_out), 32'(cur.c));
        end
        if (!reset_n) begin
            run_plots = 0;
        end else begin
            if (bus.plot) run_plots++;
            if (bus.done) begin
                chk("run_plot_count", 32'(run_plots), 32'(m_run_len));
                run_plots = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic       cap_plot[NCAP];
    logic       cap_busy[NCAP];
    logic       cap_done[NCAP];
    logic [7:0] cap_x[NCAP];
    logic [6:0] cap_y[NCAP];
    logic [2:0] cap_c[NCAP];

    // Issue go (sampled at edge 0) and capture outputs after edges 1..n. A go with junk
    // coordinates is injected after edges g1/g2; reset is asserted after edge rst_at.
    task automatic run(input logic [7:0] x, input logic [6:0] y, input logic [24:0] s,
                       input logic [2:0] c, input int n, input int g1, input int g2,
                       input int rst_at);
        for (int k = 0; k < NCAP; k++) begin
            cap_plot[k] = 1'b0; cap_busy[k] = 1'b0; cap_done[k] = 1'b0;
            cap_x[k] = 8'd0; cap_y[k] = 7'd0; cap_c[k] = 3'd0;
        end
        bus.go = 1'b1; bus.x_in = x; bus.y_in = y; bus.shape = s; bus.colour_in = c;
        @(posedge clk);
        #1 bus.go = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1 bus.go = 1'b0;
            @(negedge clk);
            cap_plot[k] = bus.plot; cap_busy[k] = bus.busy; cap_done[k] = bus.done;
            cap_x[k] = bus.x_vga; cap_y[k] = bus.y_vga; cap_c[k] = bus.colour_out;
            if (k == g1 || k == g2) begin
                bus.go = 1'b1; bus.x_in = 8'd99; bus.y_in = 7'd99;
                bus.shape = 25'd0; bus.colour_in = 3'd1;
            end
            if (k == rst_at) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rst_async_plot", 32'(bus.plot), 32'd0);
                chk("rst_async_busy", 32'(bus.busy), 32'd0);
                repeat (2) @(negedge clk);
                #1 reset_n = 1'b1;
                break;
            end
        end
    endtask

    function automatic int sum_plots();
        int t = 0;
        for (int k = 0; k < NCAP; k++) t += int'(cap_plot[k]);
        return t;
    endfunction

    initial begin
        bus.go = 1'b0; bus.shape = 25'd0; bus.x_in = 8'd0; bus.y_in = 7'd0;
        bus.colour_in = 3'd0;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_plot", 32'(bus.plot), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_xyc", {13'd0, bus.x_vga, bus.y_vga, bus.colour_out}, 32'd0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);

        // First go: draw only.
        run(8'd10, 7'd20, SHP, 3'b100, 30, -1, -1, -1);
        chk("r1_first_x", 32'(cap_x[1]), 32'd10);
        chk("r1_first_y", 32'(cap_y[1]), 32'd20);
        chk("r1_first_c", 32'(cap_c[1]), 32'd4);
        chk("r1_pix01_c", 32'(cap_c[6]), 32'd4);
        chk("r1_pix11_c", 32'(cap_c[7]), 32'd0);
        chk("r1_last_xy", {17'd0, cap_x[25], cap_y[25]}, {17'd0, 8'd14, 7'd24});
        chk("r1_done25", 32'(cap_done[25]), 32'd0);
        chk("r1_done26", 32'(cap_done[26]), 32'd1);
        chk("r1_plots", 32'(sum_plots()), 32'd25);

        // Second go: erase old footprint then draw.
        run(8'd11, 7'd20, SHP, 3'b100, 55, -1, -1, -1);
        chk("r2_erase_first", {14'd0, cap_x[1], cap_y[1], cap_c[1]}, {14'd0, 8'd10, 7'd20, BG});
        chk("r2_erase_last", {14'd0, cap_x[25], cap_y[25], cap_c[25]}, {14'd0, 8'd14, 7'd24, BG});
        chk("r2_draw_first", {14'd0, cap_x[26], cap_y[26], cap_c[26]},
            {14'd0, 8'd11, 7'd20, 3'b100});
        chk("r2_done50", 32'(cap_done[50]), 32'd0);
        chk("r2_done51", 32'(cap_done[51]), 32'd1);
        chk("r2_plots", 32'(sum_plots()), 32'd50);

        // Wrap-around addresses.
        run(8'd254, 7'd126, 25'h1FFFFFF, 3'b011, 55, -1, -1, -1);
        chk("wrap_x0", 32'(cap_x[26]), 32'd254);
        chk("wrap_x1", 32'(cap_x[27]), 32'd255);
        chk("wrap_x2", 32'(cap_x[28]), 32'd0);
        chk("wrap_x4", 32'(cap_x[30]), 32'd2);
        chk("wrap_y1", 32'(cap_y[31]), 32'd127);
        chk("wrap_y2", 32'(cap_y[36]), 32'd0);
        chk("wrap_y4", 32'(cap_y[46]), 32'd2);

        // go pulses while busy and coincident with done are ignored.
        run(8'd5, 7'd5, SHP, 3'b111, 56, 10, 51, -1);
        chk("ign_erase_first", {17'd0, cap_x[1], cap_y[1]}, {17'd0, 8'd254, 7'd126});
        chk("ign_draw_first", {17'd0, cap_x[26], cap_y[26]}, {17'd0, 8'd5, 7'd5});
        chk("ign_draw_last", {17'd0, cap_x[50], cap_y[50]}, {17'd0, 8'd9, 7'd9});
        chk("ign_done51", 32'(cap_done[51]), 32'd1);
        chk("ign_plots", 32'(sum_plots()), 32'd50);

        // Reset in the 10th draw cycle aborts; next go skips erase.
        run(8'd40, 7'd40, SHP, 3'b010, 40, -1, -1, 35);
        chk("abort_pre_xy", {16'd0, cap_plot[35], cap_x[35], cap_y[35]},
            {16'd0, 1'b1, 8'd44, 7'd41});
        repeat (3) @(negedge clk);
        chk("abort_idle_plot", 32'(bus.plot), 32'd0);
        run(8'd0, 7'd0, SHP, 3'b101, 30, -1, -1, -1);
        chk("post_rst_first", {14'd0, cap_x[1], cap_y[1], cap_c[1]}, {14'd0, 8'd0, 7'd0, 3'b101});
        chk("post_rst_done26", 32'(cap_done[26]), 32'd1);
        chk("post_rst_plots", 32'(sum_plots()), 32'd25);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
